// File: rtl/dp_tile_sequencer.sv
// dp_tile_sequencer: splits a KxN matrix-vector job into engine tiles and sequences their streams (pooling under DP_TILE_SEQ_POOL_EN).
// Latency: first mat/vec request 2 cycles after start; dp_start one cycle after the last load beat; all outputs registered.
// Backpressure: progresses only on stream beat strobes and a fresh engine done flag; abort_i drops back to IDLE at once.
module dp_tile_sequencer #(
    parameter int RRAM_DOTP_HEIGHT    = 32,
    parameter int RRAM_DOTP_WIDTH     = 32,
    parameter int RESULTS_BUFFER_SIZE = 4,
    parameter int MAT_BEAT_ELEMS      = 4,
    parameter int VEC_BEAT_ELEMS      = 1,
    parameter int RES_BEAT_ELEMS      = 1,
    parameter int DIM_W               = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [DIM_W-1:0]                       mat_rows_i,
    input  logic [DIM_W-1:0]                       mat_cols_i,
`ifdef DP_TILE_SEQ_POOL_EN
    input  logic                                   pool_mode_i,
`endif
    input  logic                                   mat_beat_i,
    input  logic                                   vec_beat_i,
    input  logic                                   res_beat_i,
    input  logic                                   dp_done_i,
    output logic                                   mat_req_o,
    output logic                                   vec_req_o,
    output logic [DIM_W-1:0]                       mat_len_o,
    output logic [DIM_W-1:0]                       vec_len_o,
    output logic                                   clear_o,
    output logic                                   dp_start_o,
    output logic [$clog2(RRAM_DOTP_WIDTH):0]       sub_mat_width_o,
    output logic [$clog2(RRAM_DOTP_HEIGHT):0]      sub_mat_height_o,
    output logic                                   res_to_buffer_o,
    output logic [$clog2(RESULTS_BUFFER_SIZE)-1:0] current_res_o,
    output logic                                   res_transfer_enable_o,
    output logic                                   dp_pool_sel_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o
);

    localparam int SW_W  = $clog2(RRAM_DOTP_WIDTH) + 1;
    localparam int SH_W  = $clog2(RRAM_DOTP_HEIGHT) + 1;
    localparam int CR_W  = $clog2(RESULTS_BUFFER_SIZE);
    // Wide enough for the 9*N pooling beat count.
    localparam int CNT_W = DIM_W + 4;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_COMPUTE, S_WAIT_DP, S_DRAIN, S_NEXT, S_DONE, S_POOL
    } state_t;

    state_t            state_q;
    logic [DIM_W-1:0]  k_q, n_q;
    // Rows/cols not yet covered, counting the current tile; avoids r*H multiplies.
    logic [DIM_W-1:0]  rows_left, cols_left;
    logic [CNT_W-1:0]  mat_cnt, vec_cnt, res_cnt, mat_tgt, vec_tgt, res_tgt;
    logic              wait_first;

    logic              last_row, last_col, tile_go, pool_job;
    logic              mat_ok, vec_ok, res_ok;
    logic [CNT_W-1:0]  mat_cnt_nx, vec_cnt_nx, res_cnt_nx, nmat, nvec, nres, pool_mat;
    logic [DIM_W-1:0]  nrl, ncl;
    logic [SH_W-1:0]   nsh;
    logic [SW_W-1:0]   nsw;
    logic [CR_W-1:0]   slot_inc;

`ifdef DP_TILE_SEQ_POOL_EN
    logic pool_q;
    assign pool_job      = pool_q;
    assign dp_pool_sel_o = pool_q;
`else
    assign pool_job      = 1'b0;
    assign dp_pool_sel_o = 1'b0;
`endif

    function automatic logic [SH_W-1:0] clip_h(input logic [DIM_W-1:0] left);
        return (left >= DIM_W'(RRAM_DOTP_HEIGHT)) ? SH_W'(RRAM_DOTP_HEIGHT) : left[SH_W-1:0];
    endfunction

    function automatic logic [SW_W-1:0] clip_w(input logic [DIM_W-1:0] left);
        return (left >= DIM_W'(RRAM_DOTP_WIDTH)) ? SW_W'(RRAM_DOTP_WIDTH) : left[SW_W-1:0];
    endfunction

    // Beat counters, the geometry of the tile about to be loaded, and loop-exit tests.
    always_comb begin
        last_row   = rows_left <= DIM_W'(RRAM_DOTP_HEIGHT);
        last_col   = cols_left <= DIM_W'(RRAM_DOTP_WIDTH);
        mat_cnt_nx = mat_cnt + ((mat_beat_i && mat_cnt != mat_tgt) ? CNT_W'(1) : CNT_W'(0));
        vec_cnt_nx = vec_cnt + ((vec_beat_i && vec_cnt != vec_tgt) ? CNT_W'(1) : CNT_W'(0));
        res_cnt_nx = res_cnt + ((res_beat_i && res_cnt != res_tgt) ? CNT_W'(1) : CNT_W'(0));
        mat_ok     = mat_cnt_nx == mat_tgt;
        vec_ok     = vec_cnt_nx == vec_tgt;
        res_ok     = res_cnt_nx == res_tgt;
        nrl        = k_q;
        ncl        = n_q;
        if (state_q == S_NEXT) begin
            if (!last_row) begin
                nrl = rows_left - DIM_W'(RRAM_DOTP_HEIGHT);
                ncl = cols_left;
            end else begin
                ncl = cols_left - DIM_W'(RRAM_DOTP_WIDTH);
            end
        end
        nsh      = clip_h(nrl);
        nsw      = clip_w(ncl);
        nmat     = CNT_W'(nsh) * ((CNT_W'(nsw) + CNT_W'(MAT_BEAT_ELEMS - 1)) / CNT_W'(MAT_BEAT_ELEMS));
        nvec     = (CNT_W'(nsh) + CNT_W'(VEC_BEAT_ELEMS - 1)) / CNT_W'(VEC_BEAT_ELEMS);
        nres     = (CNT_W'(nsw) + CNT_W'(RES_BEAT_ELEMS - 1)) / CNT_W'(RES_BEAT_ELEMS);
        pool_mat = CNT_W'(n_q) * CNT_W'(9);
        slot_inc = (current_res_o == CR_W'(RESULTS_BUFFER_SIZE - 1)) ? '0 : current_res_o + CR_W'(1);
        tile_go  = (state_q == S_CLEAR && !pool_job) || (state_q == S_NEXT && !(last_row && last_col));
    end

    // Job FSM with registered outputs; abort overrides every transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            k_q <= '0; n_q <= '0; rows_left <= '0; cols_left <= '0;
            mat_cnt <= '0; vec_cnt <= '0; res_cnt <= '0;
            mat_tgt <= '0; vec_tgt <= '0; res_tgt <= '0;
            wait_first <= 1'b0;
            mat_req_o <= 1'b0; vec_req_o <= 1'b0; mat_len_o <= '0; vec_len_o <= '0;
            clear_o <= 1'b0; dp_start_o <= 1'b0;
            sub_mat_width_o <= '0; sub_mat_height_o <= '0;
            res_to_buffer_o <= 1'b0; current_res_o <= '0; res_transfer_enable_o <= 1'b0;
            busy_o <= 1'b0; done_o <= 1'b0; err_o <= 1'b0;
`ifdef DP_TILE_SEQ_POOL_EN
            pool_q <= 1'b0;
`endif
        end else begin
            mat_req_o  <= 1'b0;
            vec_req_o  <= 1'b0;
            mat_len_o  <= '0;
            vec_len_o  <= '0;
            clear_o    <= 1'b0;
            dp_start_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            if (abort_i && state_q != S_IDLE) begin
                state_q               <= S_IDLE;
                clear_o               <= 1'b1;
                busy_o                <= 1'b0;
                res_transfer_enable_o <= 1'b0;
                res_to_buffer_o       <= 1'b0;
                current_res_o         <= '0;
`ifdef DP_TILE_SEQ_POOL_EN
                pool_q                <= 1'b0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: if (start_i) begin
                        if (mat_rows_i != '0 && mat_cols_i != '0) begin
                            k_q             <= mat_rows_i;
                            n_q             <= mat_cols_i;
                            res_to_buffer_o <= mat_rows_i > DIM_W'(RRAM_DOTP_HEIGHT);
                            clear_o         <= 1'b1;
                            busy_o          <= 1'b1;
                            state_q         <= S_CLEAR;
`ifdef DP_TILE_SEQ_POOL_EN
                            pool_q          <= pool_mode_i;
`endif
                        end else begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        current_res_o <= '0;
`ifdef DP_TILE_SEQ_POOL_EN
                        if (pool_q) begin
                            state_q   <= S_POOL;
                            mat_req_o <= 1'b1;
                            mat_len_o <= pool_mat[DIM_W-1:0];
                            mat_tgt   <= pool_mat;
                            mat_cnt   <= '0;
                            res_tgt   <= CNT_W'(n_q);
                            res_cnt   <= '0;
                        end
`endif
                    end
                    S_LOAD: begin
                        mat_cnt <= mat_cnt_nx;
                        vec_cnt <= vec_cnt_nx;
                        if (mat_ok && vec_ok) begin
                            state_q               <= S_COMPUTE;
                            dp_start_o            <= 1'b1;
                            res_transfer_enable_o <= last_row;
                        end
                    end
                    S_COMPUTE: begin
                        state_q    <= S_WAIT_DP;
                        wait_first <= 1'b1;
                    end
                    // The first cycle is skipped: done may still be high from the previous tile.
                    S_WAIT_DP: begin
                        if (wait_first) begin
                            wait_first <= 1'b0;
                        end else if (dp_done_i) begin
                            if (last_row) begin
                                state_q <= S_DRAIN;
                                res_cnt <= '0;
                            end else begin
                                state_q <= S_NEXT;
                            end
                        end
                    end
                    S_DRAIN: begin
                        res_cnt <= res_cnt_nx;
                        if (res_ok) begin
                            state_q               <= S_NEXT;
                            res_transfer_enable_o <= 1'b0;
                        end
                    end
                    S_NEXT: begin
                        if (last_row && !last_col) begin
                            current_res_o <= slot_inc;
                        end else if (last_row && last_col) begin
                            state_q <= S_DONE;
                            done_o  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q         <= S_IDLE;
                        busy_o          <= 1'b0;
                        res_to_buffer_o <= 1'b0;
                        current_res_o   <= '0;
`ifdef DP_TILE_SEQ_POOL_EN
                        pool_q          <= 1'b0;
`endif
                    end
`ifdef DP_TILE_SEQ_POOL_EN
                    S_POOL: begin
                        mat_cnt <= mat_cnt_nx;
                        res_cnt <= res_cnt_nx;
                        if (mat_ok && res_ok) begin
                            state_q <= S_DONE;
                            done_o  <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
                // Entry into LOAD for the next tile, from CLEAR or NEXT.
                if (tile_go) begin
                    state_q          <= S_LOAD;
                    rows_left        <= nrl;
                    cols_left        <= ncl;
                    sub_mat_height_o <= nsh;
                    sub_mat_width_o  <= nsw;
                    mat_req_o        <= 1'b1;
                    vec_req_o        <= 1'b1;
                    mat_len_o        <= nmat[DIM_W-1:0];
                    vec_len_o        <= nvec[DIM_W-1:0];
                    mat_tgt          <= nmat;
                    vec_tgt          <= nvec;
                    res_tgt          <= nres;
                    mat_cnt          <= '0;
                    vec_cnt          <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dp_tile_sequencer.sv
// Randomized bench for dp_tile_sequencer against a tile-arithmetic reference model.
// Drives stream beats and engine done with random gaps; checks lengths, geometry and pulse timing.
// Default build only (pooling not compiled in).
module tb_dp_tile_sequencer;

    localparam int H = 32;
    localparam int W = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic [15:0] mat_rows_i = '0, mat_cols_i = '0;
    logic        mat_beat_i = 1'b0, vec_beat_i = 1'b0, res_beat_i = 1'b0, dp_done_i = 1'b0;
    logic        mat_req_o, vec_req_o, clear_o, dp_start_o, res_to_buffer_o;
    logic [15:0] mat_len_o, vec_len_o;
    logic [5:0]  sub_mat_width_o, sub_mat_height_o;
    logic [1:0]  current_res_o;
    logic        res_transfer_enable_o, dp_pool_sel_o, busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    dp_tile_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .mat_rows_i(mat_rows_i), .mat_cols_i(mat_cols_i),
        .mat_beat_i(mat_beat_i), .vec_beat_i(vec_beat_i), .res_beat_i(res_beat_i),
        .dp_done_i(dp_done_i), .mat_req_o(mat_req_o), .vec_req_o(vec_req_o),
        .mat_len_o(mat_len_o), .vec_len_o(vec_len_o), .clear_o(clear_o),
        .dp_start_o(dp_start_o), .sub_mat_width_o(sub_mat_width_o),
        .sub_mat_height_o(sub_mat_height_o), .res_to_buffer_o(res_to_buffer_o),
        .current_res_o(current_res_o), .res_transfer_enable_o(res_transfer_enable_o),
        .dp_pool_sel_o(dp_pool_sel_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_mreq = 0, n_done = 0, n_err = 0, n_clr = 0;

    always @(negedge clk_i) begin
        if (dp_start_o) n_start++;
        if (mat_req_o)  n_mreq++;
        if (done_o)     n_done++;
        if (err_o)      n_err++;
        if (clear_o)    n_clr++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One job: the model derives every tile's geometry from K, N and the tile loop order.
    task automatic run_job(input int k, input int n, input int vdly, input bit stale, input bit abrt);
        int rt, ct, s0, m0, d0, e0, c0, sh, sw, mlen, mc, vc, cyc, rc;
        rt = (k + H - 1) / H;
        ct = (n + W - 1) / W;
        s0 = n_start; m0 = n_mreq; d0 = n_done; e0 = n_err; c0 = n_clr;
        dp_done_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b1; mat_rows_i = 16'(k); mat_cols_i = 16'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        if (k == 0 || n == 0) begin
            chk("err_pulse", err_o, 1);
            chk("err_done_same_cycle", done_o, 1);
            chk("err_not_busy", busy_o, 0);
            @(negedge clk_i);
            chk("err_one_cycle", err_o, 0);
            repeat (3) @(negedge clk_i);
            @(posedge clk_i);
            chk("err_no_requests", n_mreq - m0, 0);
            chk("err_no_clear", n_clr - c0, 0);
            return;
        end
        chk("clear_pulse", clear_o, 1);
        chk("busy_in_clear", busy_o, 1);
        @(negedge clk_i);
        for (int c = 0; c < ct; c++) begin
            for (int r = 0; r < rt; r++) begin
                if (!(c == 0 && r == 0)) begin
                    for (int i = 0; i < 400 && !mat_req_o; i++) @(negedge clk_i);
                end
                sh   = (k - r * H < H) ? k - r * H : H;
                sw   = (n - c * W < W) ? n - c * W : W;
                mlen = sh * ((sw + 3) / 4);
                chk("mat_req", mat_req_o, 1);
                chk("vec_req", vec_req_o, 1);
                chk("mat_len", mat_len_o, mlen);
                chk("vec_len", vec_len_o, sh);
                chk("sub_height", sub_mat_height_o, sh);
                chk("sub_width", sub_mat_width_o, sw);
                chk("current_res", current_res_o, c % 4);
                chk("res_to_buffer", res_to_buffer_o, (rt > 1) ? 1 : 0);
                if (stale) dp_done_i = 1'b1;
                mc = 0; vc = 0; cyc = 0;
                while (mc < mlen || vc < sh) begin
                    @(posedge clk_i); #1;
                    mat_beat_i = (mc < mlen) && ($urandom_range(3) != 0);
                    vec_beat_i = (vc < sh) && (cyc >= vdly) && ($urandom_range(3) != 0);
                    if (mat_beat_i) mc++;
                    if (vec_beat_i) vc++;
                    cyc++;
                end
                @(posedge clk_i); #1;
                mat_beat_i = 1'b0; vec_beat_i = 1'b0;
                @(negedge clk_i);
                chk("dp_start_after_last_beat", dp_start_o, 1);
                chk("res_xfer_enable", res_transfer_enable_o, (r == rt - 1) ? 1 : 0);
                if (abrt) begin
                    @(posedge clk_i); #1;
                    abort_i = 1'b1;
                    @(posedge clk_i); #1;
                    abort_i = 1'b0;
                    @(negedge clk_i);
                    chk("abort_clear", clear_o, 1);
                    chk("abort_idle", busy_o, 0);
                    chk("abort_xfer_off", res_transfer_enable_o, 0);
                    repeat (4) @(negedge clk_i);
                    @(posedge clk_i);
                    chk("abort_no_done", n_done - d0, 0);
                    chk("abort_clear_count", n_clr - c0, 2);
                    return;
                end
                if (stale) begin
                    @(posedge clk_i); #1;
                    @(posedge clk_i); #1;
                    dp_done_i = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk_i);
                        chk("stale_done_ignored", mat_req_o, 0);
                    end
                    @(posedge clk_i); #1;
                end else begin
                    dp_done_i = 1'b0;
                    repeat ($urandom_range(3, 1)) @(posedge clk_i);
                    #1;
                end
                dp_done_i = 1'b1;
                if (r == rt - 1) begin
                    @(posedge clk_i);
                    rc = 0;
                    while (rc < sw) begin
                        @(posedge clk_i); #1;
                        res_beat_i = ($urandom_range(2) != 0);
                        if (res_beat_i) rc++;
                    end
                    @(posedge clk_i); #1;
                    res_beat_i = 1'b0;
                    @(negedge clk_i);
                    chk("drain_exact_req", mat_req_o, 0);
                    chk("drain_exact_done", done_o, 0);
                    chk("xfer_off_after_drain", res_transfer_enable_o, 0);
                    @(negedge clk_i);
                    if (c == ct - 1) chk("done_pulse", done_o, 1);
                    else             chk("next_col_req", mat_req_o, 1);
                end
            end
        end
        chk("busy_in_done", busy_o, 1);
        @(negedge clk_i);
        chk("done_one_cycle", done_o, 0);
        chk("idle_after_done", busy_o, 0);
        dp_done_i = 1'b0;
        @(posedge clk_i);
        chk("dp_start_count", n_start - s0, rt * ct);
        chk("mat_req_count", n_mreq - m0, rt * ct);
        chk("done_count", n_done - d0, 1);
        chk("err_count", n_err - e0, 0);
        chk("clear_count", n_clr - c0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: job did not complete, expected completion well before time limit");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_mat_req", mat_req_o, 0);
        chk("rst_clear", clear_o, 0);
        chk("rst_dp_start", dp_start_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_sub_width", sub_mat_width_o, 0);
        chk("rst_res_to_buffer", res_to_buffer_o, 0);
        chk("rst_pool_sel", dp_pool_sel_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        run_job(32, 32, 0, 1'b0, 1'b0);
        run_job(70, 40, 0, 1'b0, 1'b0);
        run_job(0, 5, 0, 1'b0, 1'b0);
        run_job(5, 0, 0, 1'b0, 1'b0);
        run_job(70, 40, 0, 1'b0, 1'b1);
        run_job(40, 10, 0, 1'b0, 1'b0);
        run_job(70, 40, 5, 1'b1, 1'b0);

        // Reset in the middle of a job.
        d0 = n_done;
        @(posedge clk_i); #1;
        start_i = 1'b1; mat_rows_i = 16'd40; mat_cols_i = 16'd40;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #2;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_mat_req", mat_req_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        chk("midrst_no_done", n_done - d0, 0);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(96, 1), $urandom_range(96, 1), $urandom_range(5),
                    1'($urandom_range(1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
